regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Requester A: ALU pipe, single-cycle results.
  - Requester B: LSU/MDU, long-latency results.
- Keeps a per-register scoreboard of outstanding long-latency destinations.
- Raises a combinational `hazard` so decode can stall RAW/WAW conflicts.
- Sits between the execute/memory stages and the register file's `reg_write` / `write_reg` / `write_data` inputs.

Parameters:
- XLEN, 32, data width of writeback values.
- NREG, 32, number of architectural registers; the index width is log2(NREG) = 5.
- RR_EN, 1, arbitration mode: 1 = round-robin between A and B; 0 = fixed priority, A wins.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  ALU writeback request.
- a_rd  in  5  ALU destination register.
- a_data  in  XLEN  ALU result.
- a_ready  out  1  ALU request accepted this cycle.
- b_valid  in  1  LSU/MDU writeback request.
- b_rd  in  5  LSU/MDU destination register.
- b_data  in  XLEN  LSU/MDU result.
- b_ready  out  1  LSU/MDU request accepted this cycle.
- iss_valid  in  1  long-latency op issued this cycle; marks iss_rd busy.
- iss_rd  in  5  destination of the issued long-latency op.
- chk_rs1  in  5  decode source 1 to check.
- chk_rs2  in  5  decode source 2 to check.
- chk_rd  in  5  decode destination to check (WAW).
- hazard  out  1  decode must stall.
- reg_write  out  1  register file write enable (registered).
- write_reg  out  5  register file write index (registered).
- write_data  out  XLEN  register file write data (registered).
- err_waw  out  1  sticky: issue attempted to an already-busy register.

Behaviour:
- Reset: while rst_n=0, asynchronously force:
  - reg_write=0, write_reg=0, write_data=0;
  - scoreboard=0, err_waw=0;
  - last-grant pointer = B, so A wins the first tie.
- The reset takes effect mid-operation with no completion: in-flight output-stage writes and pending scoreboard bits are dropped.
- Handshake:
  - A request transfers when valid & ready in the same cycle.
  - ready is combinational from the valids and the pointer; it is never asserted without the matching valid.
  - Requesters must hold valid, rd and data stable until ready.
- Arbitration:
  - Exactly one grant per cycle.
  - Only one valid: grant it.
  - Both valid, RR_EN=1: grant the requester not granted last; the pointer updates only on a tie-free or tie grant, i.e. on any grant.
  - Both valid, RR_EN=0: grant A.
- Output stage:
  - One-cycle latency. The grant in cycle N drives reg_write=1, write_reg=rd and write_data=data in cycle N+1.
  - No grant: reg_write=0; write_reg and write_data hold their values.
  - The register file never back-pressures, so no buffering is needed.
- rd==0: the request is accepted (ready=1), but reg_write stays 0 in N+1 and no scoreboard action is taken.
- Scoreboard (NREG bits):
  - Set: iss_valid & iss_rd!=0 sets bit[iss_rd] at the edge.
  - Clear: a B write in the output stage (reg_write=1 and the source tag is B) clears bit[write_reg] at the edge ending that cycle.
  - Set and clear on the same index in the same cycle: set wins, because the new op is outstanding.
  - iss_valid to an index already set and not being cleared that cycle: err_waw←1 (sticky until reset); the bit stays set.
  - bit[0] is permanently 0.
- Hazard (combinational, index 0 never matches):
  - hazard = sb[chk_rs1] | sb[chk_rs2] | sb[chk_rd]
  - | (reg_write & write_reg!=0 & write_reg ∈ {chk_rs1, chk_rs2}).
  - The output-stage term covers the cycle in which a write is presented but not yet visible through the register file's combinational read.
- ALU writes never touch the scoreboard. An A write to a busy register is not blocked; decode prevents that case through hazard on chk_rd.

Decomposition:
- Shared package `rv32_pkg`:
  - XLEN, NREG, REG_IDX_W=5;
  - source-tag typedef `wb_src_t` {SRC_A, SRC_B};
  - constant `X0=5'd0`.
- One natural sub-module, `wb_rr_arb2`: the 2-input round-robin/fixed arbiter with the pointer flop (~40 lines).
- Scoreboard and output stage stay in the top level.

Test Plan:
- Reset/idle: pulse rst_n low mid-cycle with scoreboard bits set → reg_write=0, hazard=0 and err_waw=0 immediately, with no clock edge required.
- Single A: a_valid=1, a_rd=5, a_data=0x1234_5678 → a_ready=1 that cycle; next cycle reg_write=1, write_reg=5, write_data=0x12345678; hazard=1 for chk_rs1=5 during that cycle only.
- Contention: a_valid=b_valid=1 for 4 cycles, RR_EN=1 → grants A,B,A,B; with RR_EN=0 → A,A,A,A and b_ready=0 throughout.
- Scoreboard round trip: iss_valid with iss_rd=10 → hazard=1 for chk_rs2=10 until B writes rd=10; hazard stays 1 through the output cycle, then drops to 0.
- Same-cycle set/clear: B writeback of x7 in the output stage while iss_valid with iss_rd=7 → bit 7 remains set and err_waw stays 0.
- x0 and WAW error:
  - b_rd=0 → accepted, reg_write=0.
  - iss_rd=0 → hazard stays 0.
  - Two issues to x3 without writeback → err_waw=1 and stays 1 until reset.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 integer-core definitions used by the writeback arbiter.
//   XLEN       : data width of a writeback value
//   NREG       : number of architectural registers
//   REG_IDX_W  : width of a register index
//   X0         : index of the hardwired-zero register
//   wb_src_t   : which requester produced an output-stage write
package rv32_pkg;

  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = $clog2(NREG);

  localparam logic [REG_IDX_W-1:0] X0 = '0;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } wb_src_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus carrying both requesters' valid/ready handshakes.
//   a_valid/a_rd/a_data : ALU request, a_ready returned by the arbiter
//   b_valid/b_rd/b_data : LSU/MDU request, b_ready returned by the arbiter
// master modport : the requesters' side
// slave  modport : the arbiter's side
interface regfile_wb_arbiter_if
  import rv32_pkg::*;
#(
  parameter int XLEN = rv32_pkg::XLEN
);

  logic                 a_valid;
  logic [REG_IDX_W-1:0] a_rd;
  logic [XLEN-1:0]      a_data;
  logic                 a_ready;

  logic                 b_valid;
  logic [REG_IDX_W-1:0] b_rd;
  logic [XLEN-1:0]      b_data;
  logic                 b_ready;

  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/wb_rr_arb2.sv
// Two-input arbiter for the register-file write port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   a_req, b_req   : request lines (the requesters' valids)
//   a_gnt, b_gnt   : one-hot grant, combinational from requests and pointer
// RR_EN=1 alternates on a tie; RR_EN=0 always favours A. The pointer
// remembers the last winner and resets to B so A wins the first tie.
module wb_rr_arb2
  import rv32_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  wb_src_t last_q, last_d;

  always_comb begin
    // NOTE: every output gets a default before any branch; a path that
    // leaves a combinational signal unassigned would infer a latch.
    a_gnt  = 1'b0;
    b_gnt  = 1'b0;
    last_d = last_q;

    if (a_req && b_req) begin
      if ((RR_EN != 0) && (last_q == SRC_A)) b_gnt = 1'b1;
      else                                   a_gnt = 1'b1;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req;
    end

    if (a_gnt)      last_d = SRC_A;
    else if (b_gnt) last_d = SRC_B;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SRC_B;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with long-latency scoreboard.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wb (slave)            : A (ALU) and B (LSU/MDU) writeback handshakes
//   iss_valid, iss_rd     : long-latency issue, marks iss_rd outstanding
//   chk_rs1/chk_rs2/chk_rd: decode operands checked for RAW/WAW
//   hazard                : combinational stall request to decode
//   reg_write/write_reg/write_data : registered register-file write port
//   err_waw               : sticky, issue to an already-outstanding register
module regfile_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int XLEN  = rv32_pkg::XLEN,
  parameter int NREG  = rv32_pkg::NREG,
  parameter int RR_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  wb,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rd,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  input  logic [REG_IDX_W-1:0] chk_rd,
  output logic                 hazard,
  output logic                 reg_write,
  output logic [REG_IDX_W-1:0] write_reg,
  output logic [XLEN-1:0]      write_data,
  output logic                 err_waw
);

  // ---------------------------------------------------------------- arbiter
  logic a_gnt, b_gnt;

  wb_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .a_req (wb.a_valid),
    .b_req (wb.b_valid),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  assign wb.a_ready = a_gnt;
  assign wb.b_ready = b_gnt;

  // ----------------------------------------------------------- output stage
  logic                 reg_write_q,  reg_write_d;
  logic [REG_IDX_W-1:0] write_reg_q,  write_reg_d;
  logic [XLEN-1:0]      write_data_q, write_data_d;
  wb_src_t              src_q,        src_d;

  // A grant to x0 is consumed but never reaches the register file.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    src_d        = src_q;
    if (a_gnt) begin
      reg_write_d  = (wb.a_rd != X0);
      write_reg_d  = wb.a_rd;
      write_data_d = wb.a_data;
      src_d        = SRC_A;
    end else if (b_gnt) begin
      reg_write_d  = (wb.b_rd != X0);
      write_reg_d  = wb.b_rd;
      write_data_d = wb.b_data;
      src_d        = SRC_B;
    end
  end

  // ------------------------------------------------------------- scoreboard
  logic [NREG-1:0] sb_q, sb_d;
  logic [NREG-1:0] sb_set, sb_clr;
  logic            err_waw_q, err_waw_d;

  // Set is applied after clear so a same-cycle reissue stays outstanding;
  // an issue only flags WAW when the bit survives this cycle's clear.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (iss_valid && (iss_rd != X0))        sb_set[iss_rd]      = 1'b1;
    if (reg_write_q && (src_q == SRC_B))    sb_clr[write_reg_q] = 1'b1;
    sb_d      = (sb_q & ~sb_clr) | sb_set;
    sb_d[0]   = 1'b0;
    err_waw_d = err_waw_q | (|(sb_set & sb_q & ~sb_clr));
  end

  // ------------------------------------------------------------------ flops
  // NOTE: the scoreboard is a plain flop vector, not a RAM, so it is reset
  // with everything else; stale busy bits must not survive a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= X0;
      write_data_q <= '0;
      src_q        <= SRC_A;
      sb_q         <= '0;
      err_waw_q    <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      src_q        <= src_d;
      sb_q         <= sb_d;
      err_waw_q    <= err_waw_d;
    end
  end

  // ----------------------------------------------------------------- hazard
  // The write being presented this cycle is not yet readable from the
  // register file, so a matching source must also stall. sb_q[0] is always
  // clear and write_reg_q==0 never writes, so x0 never raises a hazard.
  logic wr_inflight_hit;

  assign wr_inflight_hit = reg_write_q && (write_reg_q != X0) &&
                           ((write_reg_q == chk_rs1) || (write_reg_q == chk_rs2));

  assign hazard     = sb_q[chk_rs1] | sb_q[chk_rs2] | sb_q[chk_rd] | wr_inflight_hit;
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign err_waw    = err_waw_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) wbi ();
  regfile_wb_arbiter_if #(.XLEN(XLEN)) wbf ();

  logic        iss_valid;
  logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic        hazard, reg_write, err_waw;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        fp_hazard, fp_reg_write, fp_err_waw;
  logic [4:0]  fp_write_reg;
  logic [31:0] fp_write_data;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .wb(wbi.slave),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .err_waw(err_waw)
  );

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(32), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .wb(wbf.slave),
    .iss_valid(1'b0), .iss_rd(5'd0),
    .chk_rs1(5'd0), .chk_rs2(5'd0), .chk_rd(5'd0),
    .hazard(fp_hazard), .reg_write(fp_reg_write), .write_reg(fp_write_reg),
    .write_data(fp_write_data), .err_waw(fp_err_waw)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of the round-robin instance.
  bit [31:0] m_busy;       // outstanding long-latency destinations
  bit        m_err;
  bit        m_prev_b;     // last grant went to B
  bit        m_wr_en;
  bit        m_wr_b;
  bit [4:0]  m_wr_reg;
  bit [31:0] m_wr_data;
  bit        g_a, g_b;     // model grants of the most recent step

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_err = 0; m_prev_b = 1; m_wr_en = 0; m_wr_b = 0;
    m_wr_reg = '0; m_wr_data = '0;
  endtask

  task automatic idle();
    wbi.a_valid = 0; wbi.a_rd = 0; wbi.a_data = 0;
    wbi.b_valid = 0; wbi.b_rd = 0; wbi.b_data = 0;
    wbf.a_valid = 0; wbf.a_rd = 0; wbf.a_data = 0;
    wbf.b_valid = 0; wbf.b_rd = 0; wbf.b_data = 0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
  endtask

  task automatic sync_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: called just after a falling edge with inputs applied;
  // returns at the next falling edge.
  task automatic step();
    bit ea, eb, eh;
    bit [31:0] nb;
    #1;
    ea = 0; eb = 0;
    if (wbi.a_valid && wbi.b_valid) begin
      ea = m_prev_b;
      eb = !m_prev_b;
    end else begin
      ea = wbi.a_valid;
      eb = wbi.b_valid;
    end
    eh = m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd] |
         (m_wr_en && m_wr_reg != 0 && (m_wr_reg == chk_rs1 || m_wr_reg == chk_rs2));
    check("a_ready", wbi.a_ready, ea);
    check("b_ready", wbi.b_ready, eb);
    check("hazard",  hazard, eh);
    g_a = ea;
    g_b = eb;

    nb = m_busy;
    if (m_wr_en && m_wr_b) nb[m_wr_reg] = 0;
    if (iss_valid && iss_rd != 0) begin
      if (nb[iss_rd]) m_err = 1;
      nb[iss_rd] = 1;
    end
    m_busy = nb;
    if (ea || eb) begin
      m_prev_b  = eb;
      m_wr_b    = eb;
      m_wr_reg  = ea ? wbi.a_rd : wbi.b_rd;
      m_wr_data = ea ? wbi.a_data : wbi.b_data;
      m_wr_en   = (m_wr_reg != 0);
    end else begin
      m_wr_en = 0;
    end

    @(posedge clk);
    #1;
    check("reg_write",  reg_write, m_wr_en);
    check("write_reg",  write_reg, m_wr_reg);
    check("write_data", write_data, m_wr_data);
    check("err_waw",    err_waw, m_err);
    @(negedge clk);
  endtask

  initial begin
    bit [3:0] rr_seq;

    idle();
    model_reset();
    #3;
    check("rst_reg_write",  reg_write, 1'b0);
    check("rst_write_reg",  write_reg, 5'd0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_hazard",     hazard, 1'b0);
    check("rst_err_waw",    err_waw, 1'b0);
    check("rst_fp_reg_write", fp_reg_write, 1'b0);
    check("rst_fp_hazard",  fp_hazard, 1'b0);
    check("rst_fp_err_waw", fp_err_waw, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single ALU write and its output-stage hazard window.
    wbi.a_valid = 1; wbi.a_rd = 5; wbi.a_data = 32'h1234_5678; chk_rs1 = 5;
    #1;
    check("single_a_ready", wbi.a_ready, 1'b1);
    step();
    wbi.a_valid = 0;
    check("single_reg_write",  reg_write, 1'b1);
    check("single_write_reg",  write_reg, 5'd5);
    check("single_write_data", write_data, 32'h1234_5678);
    check("single_hazard_on",  hazard, 1'b1);
    step();
    check("single_hazard_off", hazard, 1'b0);
    check("single_idle_write", reg_write, 1'b0);

    // Contention: round-robin alternates from A; fixed priority keeps A.
    idle();
    sync_reset();
    wbi.a_valid = 1; wbi.a_rd = 3;  wbi.a_data = 32'haaaa_0001;
    wbi.b_valid = 1; wbi.b_rd = 12; wbi.b_data = 32'hbbbb_0002;
    wbf.a_valid = 1; wbf.a_rd = 3;  wbf.a_data = 32'haaaa_0001;
    wbf.b_valid = 1; wbf.b_rd = 12; wbf.b_data = 32'hbbbb_0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      rr_seq[i] = wbi.b_ready;
      check("fp_a_ready", wbf.a_ready, 1'b1);
      check("fp_b_ready", wbf.b_ready, 1'b0);
      step();
      if (i > 0) check("fp_write_reg", fp_write_reg, 5'd3);
    end
    check("rr_order_ABAB", rr_seq, 4'b1010);
    check("fp_write_data", fp_write_data, 32'haaaa_0001);

    // Scoreboard round trip on x10.
    idle();
    iss_valid = 1; iss_rd = 10; chk_rs2 = 10;
    step();
    iss_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check("sb10_busy", hazard, 1'b1);
      step();
    end
    wbi.b_valid = 1; wbi.b_rd = 10; wbi.b_data = 32'hdead_beef;
    step();
    wbi.b_valid = 0;
    check("sb10_output_cycle", hazard, 1'b1);
    step();
    check("sb10_cleared", hazard, 1'b0);

    // Same-cycle clear and reissue on x7.
    idle();
    iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0;
    wbi.b_valid = 1; wbi.b_rd = 7; wbi.b_data = 32'h0000_0777;
    step();
    wbi.b_valid = 0;
    iss_valid = 1; iss_rd = 7;
    step();
    iss_valid = 0; chk_rd = 7;
    #1;
    check("x7_still_busy", hazard, 1'b1);
    check("x7_no_err",     err_waw, 1'b0);
    step();

    // x0 handling.
    idle();
    wbi.b_valid = 1; wbi.b_rd = 0; wbi.b_data = 32'hffff_ffff;
    #1;
    check("x0_b_ready", wbi.b_ready, 1'b1);
    step();
    wbi.b_valid = 0;
    check("x0_no_write", reg_write, 1'b0);
    iss_valid = 1; iss_rd = 0;
    step();
    iss_valid = 0;
    check("x0_no_hazard", hazard, 1'b0);

    // Double issue to x3 raises a sticky WAW error.
    iss_valid = 1; iss_rd = 3;
    step();
    step();
    iss_valid = 0;
    check("waw_set", err_waw, 1'b1);
    step();
    step();
    check("waw_sticky", err_waw, 1'b1);

    // Asynchronous reset mid-cycle with work in flight.
    iss_valid = 1; iss_rd = 9;
    wbi.a_valid = 1; wbi.a_rd = 4; wbi.a_data = 32'h4444_4444;
    step();
    idle();
    chk_rs1 = 9; chk_rs2 = 3;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_reg_write", reg_write, 1'b0);
    check("async_rst_hazard",    hazard, 1'b0);
    check("async_rst_err_waw",   err_waw, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic; requesters hold their request until accepted.
    g_a = 1; g_b = 1;
    for (int i = 0; i < 400; i++) begin
      if (!(wbi.a_valid && !g_a)) begin
        wbi.a_valid = ($urandom_range(0, 2) != 0);
        wbi.a_rd    = 5'($urandom_range(0, 31));
        wbi.a_data  = $urandom;
      end
      if (!(wbi.b_valid && !g_b)) begin
        wbi.b_valid = ($urandom_range(0, 1) != 0);
        wbi.b_rd    = 5'($urandom_range(0, 31));
        wbi.b_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 7) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      chk_rs1   = 5'($urandom_range(0, 31));
      chk_rs2   = 5'($urandom_range(0, 31));
      chk_rd    = 5'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
